regstorage_write_arbiter: RTL and testbench

//  Shares the two write ports (A, B) of the 4x8 register storage between NUM_REQ requesters.
//  - Grants up to two writes per cycle, round-robin fair.
//  - Never issues two writes to the same address in one cycle, so no silent overwrite.
//  - Outputs drive the storage write_enable/address/data pins directly.
//  - Read ports are not touched.

---
 rtl/regwr_pkg.sv | 14 +
 rtl/regwr_rr_pick.sv | 32 +++
 rtl/regstorage_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_regstorage_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regwr_pkg.sv
// Shared constants and helpers for the register-storage write arbiter.
// Optional feature macro: REGWR_GRANT_CNT_EN (see regstorage_write_arbiter).
package regwr_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned NUM_REGS   = 4;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/regwr_rr_pick.sv
// Round-robin picker: first set bit of mask_i scanning upward from start_i,
// wrapping from N-1 to 0. Returns one-hot, binary index and a found flag.
module regwr_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  logic [PW-1:0] cand;

  // Scan N positions starting at start_i; the first requesting one wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = PW'((32'(start_i) + i) % N);
      if (!found_o && mask_i[cand]) begin
        found_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regstorage_write_arbiter.sv
// Shares storage write ports A and B between NUM_REQ requesters, up to two
// grants per cycle, round-robin fair, never two writes to one address.
// Define REGWR_GRANT_CNT_EN to add a saturating accepted-write counter port.
module regstorage_write_arbiter
  import regwr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic                      write_enable_A,
  output logic [ADDR_W-1:0]         write_address_A,
  output logic [DATA_W-1:0]         data_input_A,
  output logic                      write_enable_B,
  output logic [ADDR_W-1:0]         write_address_B,
  output logic [DATA_W-1:0]         data_input_B,
  output logic                      collision
`ifdef REGWR_GRANT_CNT_EN
  ,
  output logic [15:0]               grant_count
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  logic [PW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] mask_a, mask_b, same_a;
  logic [NUM_REQ-1:0] oh_a, oh_b;
  logic [PW-1:0]      idx_a, idx_b;
  logic               found_a, found_b;
  logic [ADDR_W-1:0]  addr_a;
  logic               collision_d;

  logic               we_a_q, we_b_q, col_q;
  logic [ADDR_W-1:0]  addr_a_q, addr_b_q;
  logic [DATA_W-1:0]  data_a_q, data_b_q;

  assign mask_a = hold ? '0 : req_valid;

  regwr_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_a (
    .mask_i  (mask_a),
    .start_i (rr_q),
    .onehot_o(oh_a),
    .idx_o   (idx_a),
    .found_o (found_a)
  );

  assign addr_a = addr_arr[idx_a];

  // Requesters sharing slot A's address stall this cycle and flag a collision.
  always_comb begin
    same_a = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      same_a[i] = found_a && mask_a[i] && (addr_arr[i] == addr_a);
    end
    mask_b      = mask_a & ~oh_a & ~same_a;
    collision_d = |(same_a & ~oh_a);
  end

  // Starting B's scan at rr_q is equivalent to continuing past A, since A is
  // the first valid requester from rr_q and it is removed from mask_b.
  regwr_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_b (
    .mask_i  (mask_b),
    .start_i (rr_q),
    .onehot_o(oh_b),
    .idx_o   (idx_b),
    .found_o (found_b)
  );

  assign req_ready = oh_a | oh_b;

  // Pointer advances past the last granted requester (B follows A in scan order).
  always_comb begin
    rr_d = rr_q;
    if (found_b) begin
      rr_d = PW'(rr_next(32'(idx_b), NUM_REQ));
    end else if (found_a) begin
      rr_d = PW'(rr_next(32'(idx_a), NUM_REQ));
    end
  end

  // Pointer, write-port output registers and collision flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_q     <= '0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      col_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      we_a_q   <= found_a;
      we_b_q   <= found_b;
      addr_a_q <= addr_a;
      addr_b_q <= addr_arr[idx_b];
      data_a_q <= data_arr[idx_a];
      data_b_q <= data_arr[idx_b];
      col_q    <= collision_d;
    end
  end

  assign write_enable_A  = we_a_q;
  assign write_address_A = addr_a_q;
  assign data_input_A    = data_a_q;
  assign write_enable_B  = we_b_q;
  assign write_address_B = addr_b_q;
  assign data_input_B    = data_b_q;
  assign collision       = col_q;

`ifdef REGWR_GRANT_CNT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + 17'(found_a) + 17'(found_b);

  // Saturating count of accepted writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_sum[16] ? '1 : cnt_sum[15:0];
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_regstorage_write_arbiter.sv
// Directed self-checking bench for regstorage_write_arbiter (NUM_REQ=4).
module tb_regstorage_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        hold;
  logic        write_enable_A, write_enable_B;
  logic [1:0]  write_address_A, write_address_B;
  logic [7:0]  data_input_A, data_input_B;
  logic        collision;
`ifdef REGWR_GRANT_CNT_EN
  logic [15:0] grant_count;
  logic [15:0] cnt_snap;
`endif

  int checks   = 0;
  int failures = 0;

  regstorage_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .hold           (hold),
    .write_enable_A (write_enable_A),
    .write_address_A(write_address_A),
    .data_input_A   (data_input_A),
    .write_enable_B (write_enable_B),
    .write_address_B(write_address_B),
    .data_input_B   (data_input_B),
    .collision      (collision)
`ifdef REGWR_GRANT_CNT_EN
    ,
    .grant_count    (grant_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    req_addr[i*2 +: 2] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic we, input logic [1:0] a, input logic [7:0] d);
    check({tag, "_weA"}, 32'(write_enable_A), 32'(we));
    if (we) begin
      check({tag, "_addrA"}, 32'(write_address_A), 32'(a));
      check({tag, "_dataA"}, 32'(data_input_A), 32'(d));
    end
  endtask

  task automatic chk_b(input string tag, input logic we, input logic [1:0] a, input logic [7:0] d);
    check({tag, "_weB"}, 32'(write_enable_B), 32'(we));
    if (we) begin
      check({tag, "_addrB"}, 32'(write_address_B), 32'(a));
      check({tag, "_dataB"}, 32'(data_input_B), 32'(d));
    end
  endtask

  initial begin
    RST = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    RST = 1'b0;
    #1;
    check("rst_weA",  32'(write_enable_A),  32'd0);
    check("rst_weB",  32'(write_enable_B),  32'd0);
    check("rst_addrA", 32'(write_address_A), 32'd0);
    check("rst_dataA", 32'(data_input_A),    32'd0);
    check("rst_addrB", 32'(write_address_B), 32'd0);
    check("rst_dataB", 32'(data_input_B),    32'd0);
    check("rst_col",  32'(collision),       32'd0);

    // Single request from req0
    req_valid = 4'b0001; set_req(0, 2'd2, 8'hA5);
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk_a("single", 1'b1, 2'd2, 8'hA5);
    chk_b("single", 1'b0, 2'd0, 8'h00);
    req_valid = '0;
    tick();
    check("idle_weA", 32'(write_enable_A), 32'd0);

    // Mid-cycle reset with writes pending
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h50 + i));
    tick();
    check("prerst_weA", 32'(write_enable_A), 32'd1);
    check("prerst_weB", 32'(write_enable_B), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("midrst_weA", 32'(write_enable_A), 32'd0);
    check("midrst_weB", 32'(write_enable_B), 32'd0);
    check("midrst_addrA", 32'(write_address_A), 32'd0);
    check("midrst_dataB", 32'(data_input_B), 32'd0);
    #2 RST = 1'b0; req_valid = '0;
    tick();

    // Two distinct addresses, pointer at 0, B wraps pointer back to 0
    req_valid = 4'b1010; set_req(1, 2'd1, 8'h11); set_req(3, 2'd3, 8'h33);
    #1 check("dual_ready", 32'(req_ready), 32'hA);
    tick();
    chk_a("dual", 1'b1, 2'd1, 8'h11);
    chk_b("dual", 1'b1, 2'd3, 8'h33);

    // Same-address clash: req0 and req2 both to addr 3
    req_valid = 4'b0101; set_req(0, 2'd3, 8'hC0); set_req(2, 2'd3, 8'hC2);
    #1 check("clash1_ready", 32'(req_ready), 32'h1);
    tick();
    chk_a("clash1", 1'b1, 2'd3, 8'hC0);
    chk_b("clash1", 1'b0, 2'd0, 8'h00);
    check("clash1_col", 32'(collision), 32'd1);
    req_valid = 4'b0100;
    #1 check("clash2_ready", 32'(req_ready), 32'h4);
    tick();
    chk_a("clash2", 1'b1, 2'd3, 8'hC2);
    chk_b("clash2", 1'b0, 2'd0, 8'h00);
    check("clash2_col", 32'(collision), 32'd0);

    // Pointer now 3: lone req3 granted, pointer wraps to 0
    req_valid = 4'b1000; set_req(3, 2'd0, 8'h3C);
    #1 check("wrap_ready", 32'(req_ready), 32'h8);
    tick();
    chk_a("wrap", 1'b1, 2'd0, 8'h3C);
    chk_b("wrap", 1'b0, 2'd0, 8'h00);

    // Fairness: all valid, addr i = i
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'hF0 + i));
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("fair%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h3 : 32'hC);
      tick();
      if (k % 2 == 0) begin
        chk_a($sformatf("fair%0d", k), 1'b1, 2'd0, 8'hF0);
        chk_b($sformatf("fair%0d", k), 1'b1, 2'd1, 8'hF1);
      end else begin
        chk_a($sformatf("fair%0d", k), 1'b1, 2'd2, 8'hF2);
        chk_b($sformatf("fair%0d", k), 1'b1, 2'd3, 8'hF3);
      end
    end

    // Hold with all requesters on one address: no grants, no collision
    hold = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 2'd1, 8'(8'h70 + i));
`ifdef REGWR_GRANT_CNT_EN
    cnt_snap = grant_count;
`endif
    #1 check("hold_ready", 32'(req_ready), 32'h0);
    tick();
    check("hold_weA", 32'(write_enable_A), 32'd0);
    check("hold_weB", 32'(write_enable_B), 32'd0);
    check("hold_col", 32'(collision), 32'd0);
`ifdef REGWR_GRANT_CNT_EN
    check("hold_cnt", 32'(grant_count), 32'(cnt_snap));
`endif

    // Release hold: pointer still 0, same-address stall rotates one per cycle
    hold = 1'b0;
    #1 check("same1_ready", 32'(req_ready), 32'h1);
    tick();
    chk_a("same1", 1'b1, 2'd1, 8'h70);
    chk_b("same1", 1'b0, 2'd0, 8'h00);
    check("same1_col", 32'(collision), 32'd1);
    req_valid = 4'b1110;
    #1 check("same2_ready", 32'(req_ready), 32'h2);
    tick();
    chk_a("same2", 1'b1, 2'd1, 8'h71);
    check("same2_col", 32'(collision), 32'd1);
    req_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
